trainer_input_stepper: RTL and testbench
========================================

# trainer_input_stepper

Front-end stage of the digital trainer kit, directly upstream of the gate array that drives uo_out[6:0] from inputs A (ui_in[0]) and B (ui_in[1]). It synchronises and debounces the board's raw switches and push-buttons, then drives A/B either straight from the switches or from a 2-bit truth-table counter that walks 00, 01, 10, 11. The counter advances on a button press or on a timer, so students can watch every gate output row by row.

## Interface

Parameters
- DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a raw input is accepted; legal range ≥ 1.
- AUTO_PERIOD, default 1000: cycles between automatic advances; legal range ≥ 2.

Ports
- clk  input  1  single clock for the block.
- rst  input  1  reset, synchronous, active-high.
- sw_a_raw  input  1  raw switch for A, asynchronous.
- sw_b_raw  input  1  raw switch for B, asynchronous.
- btn_step_raw  input  1  raw step push-button, asynchronous.
- btn_mode_raw  input  1  raw mode push-button, asynchronous.
- gate_a  output  1  A to the gate array (ui_in[0]), registered.
- gate_b  output  1  B to the gate array (ui_in[1]), registered.
- step_idx  output  2  current truth-table row; gate_a = step_idx[0], gate_b = step_idx[1] when not MANUAL.
- mode  output  2  0 = MANUAL, 1 = STEP, 2 = AUTO; 3 is never driven.
- step_pulse  output  1  one-cycle high on the cycle step_idx changes by advance.
- row_wrap  output  1  one-cycle high when step_idx advances 3 → 0.

## Operation

- Conditioning: each raw input passes through two synchroniser flops, then a debouncer.
- Debouncer counter:
  - Counts while the synchronised value differs from the accepted value.
  - Clears on any cycle where the two agree.
  - When the count reaches DEBOUNCE_CYCLES, the accepted value flips and the counter clears.
- Button events: a rising edge of an accepted button value produces a one-cycle event (step_ev, mode_ev). Falling edges produce nothing.
- Mode FSM: MANUAL → STEP → AUTO → MANUAL, advancing on mode_ev.
  - On entering STEP or AUTO: step_idx := 0, auto timer := 0, no step_pulse.
- MANUAL:
  - gate_a/gate_b follow the accepted sw_a/sw_b.
  - step_idx holds its value; step_ev is ignored.
- STEP:
  - step_ev advances step_idx by 1, mod 4.
  - Switches are ignored.
- AUTO:
  - The timer counts 0 … AUTO_PERIOD−1; when timer == AUTO_PERIOD−1, step_idx advances and the timer returns to 0.
  - step_ev restarts the sequence: step_idx := 0, timer := 0, no step_pulse.
- Simultaneous mode_ev and step_ev: mode_ev wins and step_ev is dropped.
- Wrap: an advance from 3 gives 0 and asserts step_pulse and row_wrap together.
- Reset:
  - Clears the synchroniser flops, accepted values, debounce counters, edge history, timer and step_idx.
  - Forces mode = MANUAL.
  - All outputs read 0 on the first cycle after the reset edge.
  - Reset asserted mid-debounce or mid-period discards partial counts.
- Counter widths: debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits; timer is $clog2(AUTO_PERIOD) bits. Neither may overflow.

## Timing

- Raw input change first sampled at edge k (held stable afterwards):
  - Accepted value changes at edge k+DEBOUNCE_CYCLES+2.
  - gate_a/gate_b (MANUAL), step_idx/step_pulse (STEP) and mode all update at edge k+DEBOUNCE_CYCLES+3.
- Bounce: a raw pulse or glitch shorter than DEBOUNCE_CYCLES cycles after synchronisation never changes the accepted value.
- AUTO advance timing: first advance AUTO_PERIOD cycles after the mode register reads AUTO; subsequent advances exactly every AUTO_PERIOD cycles.
- Output pulses: step_pulse and row_wrap are registered and coincide with the new step_idx value.
- Combinational paths: none from any input to any output.

## Structure

- Package trainer_pkg holds:
  - The mode enum: MODE_MANUAL = 2'd0, MODE_STEP = 2'd1, MODE_AUTO = 2'd2.
  - The truth-table row width constant ROW_W = 2.
- Sub-module trainer_debounce, parameterised by DEBOUNCE_CYCLES:
  - Contains the synchroniser, the debouncer and a rise-event output.
  - Instantiated four times.
- The top level holds the mode FSM, step counter, auto timer and output registers.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4 and AUTO_PERIOD = 8.

- Reset, then idle 20 cycles → all outputs 0 and mode = 0; pulse rst mid-run → outputs 0 the next cycle.
- MANUAL: drive sw_a_raw = 1 at edge k → gate_a = 1 at edge k+7; then a 3-cycle glitch on sw_b_raw → gate_b stays 0.
- Mode button pressed once → mode = 1 and step_idx = 0. Then four step presses → step_idx 1, 2, 3, 0, with step_pulse each time and row_wrap only on 3 → 0. Check gate_a/gate_b match rows 01, 10, 11, 00 and the gate array uo_out matches the AND/OR/NAND/NOR/XOR/XNOR truth table.
- Mode pressed again → mode = 2; step_idx advances every 8 cycles with the first advance 8 cycles after entry; a step press mid-period → step_idx = 0 and the timer restarts.
- Mode and step buttons with identical press timing → mode advances and step_idx does not increment.
- Third mode press → mode = 0 and gate outputs return to the accepted switch values on the same cycle.

Source files
------------

// File: rtl/trainer_pkg.sv
// Shared types for the trainer input front end.
// Mode encoding and truth-table row width.
package trainer_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_STEP   = 2'd1,
    MODE_AUTO   = 2'd2
  } mode_e;

  localparam int ROW_W = 2;

endpackage

// File: rtl/trainer_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw input.
// Emits the accepted level and a one-cycle rising-edge event.
module trainer_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      // any agreeing cycle discards the partial count
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CMAX) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_q;

endmodule

// File: rtl/trainer_input_stepper.sv
// Conditions board inputs and drives gate-array A/B from the
// switches or a 2-bit truth-table row counter.
module trainer_input_stepper
  import trainer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_a_raw,
  input  logic             sw_b_raw,
  input  logic             btn_step_raw,
  input  logic             btn_mode_raw,
  output logic             gate_a,
  output logic             gate_b,
  output logic [ROW_W-1:0] step_idx,
  output logic [1:0]       mode,
  output logic             step_pulse,
  output logic             row_wrap
);

  localparam int TW = $clog2(AUTO_PERIOD);
  localparam logic [TW-1:0] TMAX = TW'(AUTO_PERIOD - 1);

  logic w_sw_a;
  logic w_sw_b;
  logic w_step_ev;
  logic w_mode_ev;
  logic w_sw_a_rise;
  logic w_sw_b_rise;
  logic w_step_lvl;
  logic w_mode_lvl;
  logic w_unused;

  trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (sw_a_raw),
    .o_level(w_sw_a),
    .o_rise (w_sw_a_rise)
  );

  trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (sw_b_raw),
    .o_level(w_sw_b),
    .o_rise (w_sw_b_rise)
  );

  trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (btn_step_raw),
    .o_level(w_step_lvl),
    .o_rise (w_step_ev)
  );

  trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (btn_mode_raw),
    .o_level(w_mode_lvl),
    .o_rise (w_mode_ev)
  );

  assign w_unused = ^{w_sw_a_rise, w_sw_b_rise, w_step_lvl, w_mode_lvl};

  mode_e            r_mode;
  mode_e            w_mode_nxt;
  logic [ROW_W-1:0] r_idx;
  logic [ROW_W-1:0] w_idx_nxt;
  logic [TW-1:0]    r_tmr;
  logic [TW-1:0]    w_tmr_nxt;
  logic             w_adv;
  logic             r_pulse;
  logic             r_wrap;
  logic             r_gate_a;
  logic             r_gate_b;

  always_comb begin
    w_mode_nxt = r_mode;
    w_idx_nxt  = r_idx;
    w_tmr_nxt  = r_tmr;
    w_adv      = 1'b0;
    // a mode press swallows any coincident step press
    if (w_mode_ev) begin
      unique case (r_mode)
        MODE_MANUAL: w_mode_nxt = MODE_STEP;
        MODE_STEP:   w_mode_nxt = MODE_AUTO;
        default:     w_mode_nxt = MODE_MANUAL;
      endcase
      w_tmr_nxt = '0;
      if (w_mode_nxt != MODE_MANUAL) begin
        w_idx_nxt = '0;
      end
    end else begin
      unique case (r_mode)
        MODE_STEP: begin
          w_adv = w_step_ev;
        end
        MODE_AUTO: begin
          if (w_step_ev) begin
            w_idx_nxt = '0;
            w_tmr_nxt = '0;
          end else if (r_tmr == TMAX) begin
            w_adv     = 1'b1;
            w_tmr_nxt = '0;
          end else begin
            w_tmr_nxt = r_tmr + TW'(1);
          end
        end
        default: ;
      endcase
    end
    if (w_adv) begin
      w_idx_nxt = r_idx + ROW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= MODE_MANUAL;
      r_idx    <= '0;
      r_tmr    <= '0;
      r_pulse  <= 1'b0;
      r_wrap   <= 1'b0;
      r_gate_a <= 1'b0;
      r_gate_b <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_idx   <= w_idx_nxt;
      r_tmr   <= w_tmr_nxt;
      r_pulse <= w_adv;
      r_wrap  <= w_adv && (r_idx == '1);
      // gates track the mode being entered, not the one being left
      if (w_mode_nxt == MODE_MANUAL) begin
        r_gate_a <= w_sw_a;
        r_gate_b <= w_sw_b;
      end else begin
        r_gate_a <= w_idx_nxt[0];
        r_gate_b <= w_idx_nxt[1];
      end
    end
  end

  assign gate_a     = r_gate_a;
  assign gate_b     = r_gate_b;
  assign step_idx   = r_idx;
  assign mode       = r_mode;
  assign step_pulse = r_pulse;
  assign row_wrap   = r_wrap;

endmodule

// File: tb/tb_trainer_input_stepper.sv
// Directed bench for trainer_input_stepper with DEBOUNCE_CYCLES=4,
// AUTO_PERIOD=8; a step table plus hand-timed multi-cycle sequences.
module tb_trainer_input_stepper;

  localparam int DEB = 4;
  localparam int PER = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_a_raw;
  logic       sw_b_raw;
  logic       btn_step_raw;
  logic       btn_mode_raw;
  logic       gate_a;
  logic       gate_b;
  logic [1:0] step_idx;
  logic [1:0] mode;
  logic       step_pulse;
  logic       row_wrap;

  int n_cmp  = 0;
  int n_fail = 0;

  trainer_input_stepper #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_PERIOD    (PER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_a_raw    (sw_a_raw),
    .sw_b_raw    (sw_b_raw),
    .btn_step_raw(btn_step_raw),
    .btn_mode_raw(btn_mode_raw),
    .gate_a      (gate_a),
    .gate_b      (gate_b),
    .step_idx    (step_idx),
    .mode        (mode),
    .step_pulse  (step_pulse),
    .row_wrap    (row_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       m;
    logic [1:0] mode;
    logic [1:0] idx;
    logic       pulse;
    logic       wrap;
    logic [6:0] uo;
  } vec_t;

  vec_t tv[5];

  // downstream gate array: {~A, XNOR, XOR, NOR, NAND, OR, AND}
  function automatic logic [6:0] gates(input logic a, input logic b);
    return {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".gate_a"}, {7'd0, gate_a}, 8'd0);
    chk({name, ".gate_b"}, {7'd0, gate_b}, 8'd0);
    chk({name, ".idx"}, {6'd0, step_idx}, 8'd0);
    chk({name, ".mode"}, {6'd0, mode}, 8'd0);
    chk({name, ".pulse"}, {7'd0, step_pulse}, 8'd0);
    chk({name, ".wrap"}, {7'd0, row_wrap}, 8'd0);
  endtask

  logic seen;

  initial begin
    tv[0] = '{s:1'b0, m:1'b1, mode:2'd1, idx:2'd0, pulse:1'b0,
              wrap:1'b0, uo:7'b1101100};
    tv[1] = '{s:1'b1, m:1'b0, mode:2'd1, idx:2'd1, pulse:1'b1,
              wrap:1'b0, uo:7'b0010110};
    tv[2] = '{s:1'b1, m:1'b0, mode:2'd1, idx:2'd2, pulse:1'b1,
              wrap:1'b0, uo:7'b1010110};
    tv[3] = '{s:1'b1, m:1'b0, mode:2'd1, idx:2'd3, pulse:1'b1,
              wrap:1'b0, uo:7'b0100011};
    tv[4] = '{s:1'b1, m:1'b0, mode:2'd1, idx:2'd0, pulse:1'b1,
              wrap:1'b1, uo:7'b1101100};

    rst          = 1'b1;
    sw_a_raw     = 1'b0;
    sw_b_raw     = 1'b0;
    btn_step_raw = 1'b0;
    btn_mode_raw = 1'b0;
    tick(1);
    chk_all_zero("rst_first");
    rst = 1'b0;
    tick(20);
    chk_all_zero("idle");

    // switch A: accepted + registered 7 edges after first sample
    sw_a_raw = 1'b1;
    tick(7);
    chk("sw_a_early", {7'd0, gate_a}, 8'd0);
    tick(1);
    chk("sw_a_late", {7'd0, gate_a}, 8'd1);

    sw_b_raw = 1'b1;
    tick(3);
    sw_b_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (gate_b) seen = 1'b1;
    end
    chk("glitch_b", {7'd0, seen}, 8'd0);

    for (int i = 0; i < 5; i++) begin
      btn_step_raw = tv[i].s;
      btn_mode_raw = tv[i].m;
      tick(8);
      chk($sformatf("v%0d.mode", i), {6'd0, mode}, {6'd0, tv[i].mode});
      chk($sformatf("v%0d.idx", i), {6'd0, step_idx}, {6'd0, tv[i].idx});
      chk($sformatf("v%0d.pulse", i), {7'd0, step_pulse},
          {7'd0, tv[i].pulse});
      chk($sformatf("v%0d.wrap", i), {7'd0, row_wrap}, {7'd0, tv[i].wrap});
      chk($sformatf("v%0d.uo", i), {1'b0, gates(gate_a, gate_b)},
          {1'b0, tv[i].uo});
      tick(1);
      chk($sformatf("v%0d.pulse_off", i), {7'd0, step_pulse}, 8'd0);
      btn_step_raw = 1'b0;
      btn_mode_raw = 1'b0;
      tick(8);
    end

    // AUTO entry; E0 is the edge where mode becomes AUTO
    btn_mode_raw = 1'b1;
    tick(8);
    chk("auto.mode", {6'd0, mode}, 8'd2);
    chk("auto.idx0", {6'd0, step_idx}, 8'd0);
    btn_mode_raw = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      if (i == 7) chk("auto.pre1", {6'd0, step_idx}, 8'd0);
      if (i == 8) begin
        chk("auto.adv1", {6'd0, step_idx}, 8'd1);
        chk("auto.pulse1", {7'd0, step_pulse}, 8'd1);
      end
      if (i == 15) chk("auto.pre2", {6'd0, step_idx}, 8'd1);
      if (i == 16) chk("auto.adv2", {6'd0, step_idx}, 8'd2);
    end

    // step press lands at E0+27, mid-period after the E0+24 advance
    tick(3);
    btn_step_raw = 1'b1;
    tick(8);
    chk("restart.idx", {6'd0, step_idx}, 8'd0);
    chk("restart.pulse", {7'd0, step_pulse}, 8'd0);
    chk("restart.wrap", {7'd0, row_wrap}, 8'd0);
    btn_step_raw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 7) chk("restart.pre", {6'd0, step_idx}, 8'd0);
      if (i == 8) chk("restart.adv", {6'd0, step_idx}, 8'd1);
    end

    // both buttons together at E0+45; idx is 2 from the E0+43 advance
    tick(2);
    btn_step_raw = 1'b1;
    btn_mode_raw = 1'b1;
    tick(8);
    chk("both.mode", {6'd0, mode}, 8'd0);
    chk("both.idx", {6'd0, step_idx}, 8'd2);
    chk("both.pulse", {7'd0, step_pulse}, 8'd0);
    chk("both.gate_a", {7'd0, gate_a}, 8'd1);
    chk("both.gate_b", {7'd0, gate_b}, 8'd0);
    btn_step_raw = 1'b0;
    btn_mode_raw = 1'b0;
    tick(8);
    chk("manual.hold_idx", {6'd0, step_idx}, 8'd2);

    rst = 1'b1;
    tick(1);
    chk_all_zero("rst_mid");
    rst = 1'b0;
    tick(7);
    chk("post_rst.early", {7'd0, gate_a}, 8'd0);
    tick(1);
    chk("post_rst.late", {7'd0, gate_a}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
